matrix_scanner: RTL and testbench

MATRIX_SCANNER -- requirements
Module: matrix_scanner

---
 rtl/matrix_scanner.sv | 131 +++++++++++++
 tb/tb_matrix_scanner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scanner.sv
// 4x4 active-low key matrix scanner with switch decode for two players.
// Define MATRIX_SCANNER_DEBOUNCE_EN to add per-key frame-count debouncing.
module matrix_scanner #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  output logic [15:0] matrix,
  output logic [7:0]  switches_p1,
  output logic [7:0]  switches_p2,
  output logic        frame_valid
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("matrix_scanner: SETTLE_CYCLES must be 1..255");
  end
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7) begin : g_bad_debounce
    $error("matrix_scanner: DEBOUNCE_FRAMES must be 1..7");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic {DRIVE, SAMPLE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] matrix_q, matrix_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_end;

`ifdef MATRIX_SCANNER_DEBOUNCE_EN
  localparam logic [2:0] DB_TARGET = 3'(DEBOUNCE_FRAMES);
  logic [15:0][2:0] db_cnt_q, db_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    settle_d      = settle_q;
    raw_d         = raw_q;
    frame_valid_d = 1'b0;
    frame_end     = 1'b0;
    case (state_q)
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      SAMPLE: begin
        raw_d[{row_q, 2'b00} +: 4] = ~col_in;
        row_d    = row_q + 2'd1;
        settle_d = 8'd0;
        state_d  = DRIVE;
        if (row_q == 2'd3) begin
          frame_valid_d = 1'b1;
          frame_end     = 1'b1;
        end
      end
      default: state_d = DRIVE;
    endcase
  end

  // raw_d already holds the just-sampled row 3, so matrix sees the whole frame
`ifdef MATRIX_SCANNER_DEBOUNCE_EN
  always_comb begin
    matrix_d = matrix_q;
    db_cnt_d = db_cnt_q;
    if (frame_end) begin
      for (int i = 0; i < 16; i++) begin
        if (raw_d[i] != matrix_q[i]) begin
          if (db_cnt_q[i] + 3'd1 == DB_TARGET) begin
            matrix_d[i] = ~matrix_q[i];
            db_cnt_d[i] = 3'd0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 3'd1;
          end
        end else begin
          db_cnt_d[i] = 3'd0;
        end
      end
    end
  end
`else
  always_comb begin
    matrix_d = matrix_q;
    if (frame_end) begin
      matrix_d = raw_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DRIVE;
      row_q         <= 2'd0;
      settle_q      <= 8'd0;
      raw_q         <= 16'd0;
      matrix_q      <= 16'd0;
      frame_valid_q <= 1'b0;
`ifdef MATRIX_SCANNER_DEBOUNCE_EN
      db_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      settle_q      <= settle_d;
      raw_q         <= raw_d;
      matrix_q      <= matrix_d;
      frame_valid_q <= frame_valid_d;
`ifdef MATRIX_SCANNER_DEBOUNCE_EN
      db_cnt_q      <= db_cnt_d;
`endif
    end
  end

  // All rows released while reset is held
  assign row_out     = rst ? 4'hF : ~(4'b0001 << row_q);
  assign matrix      = matrix_q;
  assign frame_valid = frame_valid_q;

  assign switches_p2 = {4'b0000, matrix_q[8], matrix_q[5], matrix_q[9], matrix_q[7]};
  assign switches_p1 = {4'b0000, matrix_q[13], matrix_q[12], 1'b0, matrix_q[15]};

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed self-checking bench for matrix_scanner, default parameters.
// A behavioural key matrix answers row_out with col_in from the 'keys' vector.
module tb_matrix_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] matrix;
  logic [7:0]  switches_p1;
  logic [7:0]  switches_p2;
  logic        frame_valid;

  logic [15:0] keys;
  int          total_checks;
  int          bad_checks;

`ifdef MATRIX_SCANNER_DEBOUNCE_EN
  localparam int DBF = 4;
`else
  localparam int DBF = 1;
`endif
  localparam int FRAME = 68;

  matrix_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .row_out     (row_out),
    .col_in      (col_in),
    .matrix      (matrix),
    .switches_p1 (switches_p1),
    .switches_p2 (switches_p2),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed keys short their row to their column; pull-ups otherwise
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) col_in = col_in & ~keys[r*4 +: 4];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  // Returns cycles until frame_valid is seen high; timeout counts as a failure
  task automatic waitFrame(output int n);
    n = 0;
    while (n < 3 * FRAME) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (frame_valid) return;
    end
    checkOutput("frame_timeout", 32'(n), 32'(FRAME));
  endtask

  task automatic waitFrames(input int count);
    int n;
    for (int i = 0; i < count; i++) waitFrame(n);
  endtask

  task automatic checkKeys(input string tag, input logic [15:0] m, input logic [7:0] p1, input logic [7:0] p2);
    checkOutput({tag, "_matrix"}, 32'(matrix), 32'(m));
    checkOutput({tag, "_p1"}, 32'(switches_p1), 32'(p1));
    checkOutput({tag, "_p2"}, 32'(switches_p2), 32'(p2));
  endtask

  initial begin
    int n;
    int pulses;
    int first_pulse;
    int second_pulse;
    logic [3:0] exp_row;

    total_checks = 0;
    bad_checks   = 0;
    rst = 1'b1;
    applyStimulus(16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_row_out", 32'(row_out), 32'h0000000F);
    checkKeys("reset", 16'h0000, 8'h00, 8'h00);
    checkOutput("reset_frame_valid", 32'(frame_valid), 32'h0);

    rst = 1'b0;
    #1;
    checkOutput("release_row_out", 32'(row_out), 32'h0000000E);

    // Idle scan: row steps every 17 cycles, frame pulse every 68
    pulses = 0;
    first_pulse = 0;
    second_pulse = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 17) % 4));
      checkOutput($sformatf("idle_row_out_c%0d", k), 32'(row_out), 32'(exp_row));
      if (frame_valid) begin
        pulses++;
        if (pulses == 1) first_pulse = k;
        if (pulses == 2) second_pulse = k;
      end
    end
    checkOutput("idle_pulse_count", 32'(pulses), 32'd2);
    checkOutput("idle_first_pulse", 32'(first_pulse), 32'(FRAME));
    checkOutput("idle_second_pulse", 32'(second_pulse), 32'(2 * FRAME));
    checkKeys("idle", 16'h0000, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pulse_one_cycle", 32'(frame_valid), 32'h0);

    // Single key row 1 / col 3 -> P2 bit 0
    waitFrame(n);
    applyStimulus(16'h0080);
    if (DBF > 1) begin
      waitFrames(DBF - 1);
      checkKeys("key7_early", 16'h0000, 8'h00, 8'h00);
      waitFrames(1);
    end else begin
      waitFrames(DBF);
    end
    checkKeys("key7", 16'h0080, 8'h00, 8'h01);
    applyStimulus(16'h0000);
    waitFrames(DBF);
    checkKeys("key7_release", 16'h0000, 8'h00, 8'h00);

    // Multi-key chord including keys that map to no switch
    applyStimulus(16'hB320);
    waitFrames(DBF);
    checkKeys("chord", 16'hB320, 8'h0D, 8'h0E);
    applyStimulus(16'hFFFF);
    waitFrames(DBF);
    checkKeys("all_keys", 16'hFFFF, 8'h0D, 8'h0F);
    applyStimulus(16'h4C5F);
    waitFrames(DBF);
    checkKeys("unmapped_keys", 16'h4C5F, 8'h00, 8'h00);
    applyStimulus(16'h0000);
    waitFrames(DBF);
    checkKeys("chord_release", 16'h0000, 8'h00, 8'h00);

`ifdef MATRIX_SCANNER_DEBOUNCE_EN
    // A press one frame too short must be filtered out
    applyStimulus(16'h8000);
    waitFrames(3);
    checkKeys("bounce3", 16'h0000, 8'h00, 8'h00);
    applyStimulus(16'h0000);
    waitFrames(4);
    checkKeys("bounce3_after", 16'h0000, 8'h00, 8'h00);
`endif
    applyStimulus(16'h8000);
    waitFrames(DBF);
    checkKeys("key15", 16'h8000, 8'h01, 8'h00);
    applyStimulus(16'h0000);
    waitFrames(DBF);

    // Mid-frame reset during row 2 with key 0 held
    applyStimulus(16'h0001);
    waitFrames(DBF);
    checkKeys("key0", 16'h0001, 8'h00, 8'h00);
    n = 0;
    while (row_out != 4'b1011 && n < 2 * FRAME) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("reach_row2", 32'(row_out), 32'h0000000B);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkKeys("midreset", 16'h0000, 8'h00, 8'h00);
    checkOutput("midreset_row_out", 32'(row_out), 32'h0000000F);
    checkOutput("midreset_frame_valid", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    waitFrame(n);
    checkOutput("midreset_first_pulse", 32'(n), 32'(FRAME));
    if (DBF > 1) begin
      checkKeys("midreset_first_frame", 16'h0000, 8'h00, 8'h00);
      waitFrames(DBF - 1);
    end
    checkKeys("midreset_key0", 16'h0001, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
